bypass_select_ctrl: RTL
=======================

// Module: bypass_select_ctrl
// PURPOSE
// - Producer side of the bypass-network select interface. Tracks destination physical-register tags
//   through the same INT EX/WB and MEM MA/WB stage registers that the bypass data pipe holds.
// - Compares each consumer source tag against those tags.
// - Emits a registered per-operand select {stg, lane} that the bypass data mux consumes one cycle later.
// - Sits beside the register-read stage; drives the rA/rB/rC select fields of all consumer pipes.
// PARAMETERS
// - INT_LANES  2  integer producer lanes (tag pipe EX->WB)
// - MEM_LANES  2  load producer lanes (tag pipe MA->WB)
// - CONSUMERS  4  consumer operand slots (each slot is one rA/rB/rC operand)
// - PREG_W     7  physical register tag width
// - LANE_W     1  lane index width = max(1, $clog2(max(INT_LANES,MEM_LANES)))
// PORTS
// - clk            in   1                    clock
// - rst            in   1                    reset: synchronous, active-high
// - stall          in   1                    backend stall; hold all state
// - clear          in   1                    backend flush; invalidate all state
// - int_dst_valid  in   INT_LANES            int lane writes a register this cycle (Dst stage)
// - int_dst_preg   in   INT_LANES*PREG_W     int lane destination tag
// - mem_dst_valid  in   MEM_LANES            load lane writes a register this cycle (Dst stage)
// - mem_dst_preg   in   MEM_LANES*PREG_W     load lane destination tag
// - src_valid      in   CONSUMERS            operand slot reads a register
// - src_preg       in   CONSUMERS*PREG_W     operand source tag
// - sel_stg        out  CONSUMERS*3          0 NONE, 1 INT_EX, 2 INT_WB, 3 MEM_MA, 4 MEM_WB
// - sel_lane       out  CONSUMERS*LANE_W     producer lane for sel_stg
// - sel_hit        out  CONSUMERS            sel_stg != NONE
// BEHAVIOUR
// - Tag pipes are per lane: int Dst->EX->WB and mem Dst->MA->WB. Each stage holds {valid, preg}.
//   - Each edge, Dst input moves to EX/MA, and EX/MA moves to WB.
// - Select compare is done at cycle N and registered; the output is valid at N+1, aligned to the data stages.
//   - Compare int_dst_* and mem_dst_* (will be EX/MA at N+1). Match gives INT_EX or MEM_MA.
//   - Compare EX/MA registers (will be WB at N+1). Match gives INT_WB or MEM_WB.
//   - The WB registers are never compared; that data has already reached the register file.
// - Match condition: src_valid && producer valid && preg equal.
// - Priority (youngest wins), highest first:
//   - Dst-input int lanes, lowest lane first.
//   - Dst-input mem lanes, lowest lane first.
//   - EX int lanes.
//   - MA mem lanes.
// - No match, or src_valid=0: sel_stg=0, sel_lane=0, sel_hit=0.
// - stall=1: tag pipes and select registers hold. Inputs are ignored.
// - clear=1 (even with stall=1): all tag valids=0, all sel_stg=0, sel_lane=0, sel_hit=0 on the next edge.
// - rst=1: same as clear. rst and clear dominate stall.
// - Reset values: sel_stg=0, sel_lane=0, sel_hit=0, perf_hit_count=0.
// - Fixed latency: 1 cycle from src_* to sel_*. No handshake; the block is purely stage-locked to stall/clear.
// - Boundary cases:
//   - Duplicate tags across lanes resolve by the priority order above.
//   - A tag that appears in the Dst input and in EX at the same time resolves to the Dst input.
//   - Tag value 0 is treated like any other tag.
// CONFIGURATION
// - BYPASS_CTRL_PERF_EN defined:
//   - Adds output perf_hit_count [31:0].
//   - Each non-stalled, non-clear, non-rst edge adds popcount of the next sel_hit vector.
//   - Wraps modulo 2^32. Cleared only by rst.
// - BYPASS_CTRL_PERF_EN undefined: port and counter absent. Select behaviour is identical.
// TESTING
// - EX forward:
//   - Stimulus: cycle0 int_dst_valid[0]=1 preg=5; src_valid[0]=1 src_preg=5.
//   - Response: cycle1 sel_stg[0]=1, sel_lane[0]=0, sel_hit[0]=1.
// - WB forward:
//   - Stimulus: cycle0 mem_dst lane1 preg=9; cycle1 src[2] preg=9, no new dst.
//   - Response: cycle2 sel_stg[2]=4, sel_lane[2]=1.
// - Priority:
//   - Stimulus: cycle0 int lane1 preg=12; cycle1 mem lane0 preg=12 and src[1] preg=12.
//   - Response: cycle2 sel_stg[1]=3, lane 0 (younger Dst-input beats EX).
// - Stall hold:
//   - Stimulus: sel_stg[0]=1 valid, then stall=1 for 3 cycles while src_preg changes.
//   - Response: sel outputs unchanged all 3 cycles. After release, the pipe advances exactly once.
// - Clear during stall:
//   - Stimulus: tags 3 in EX, stall=1, clear=1 for 1 cycle; then src preg=3 with no new dst.
//   - Response: sel_stg=0, sel_hit=0.
// - Perf (BYPASS_CTRL_PERF_EN):
//   - Stimulus: 4 consumers all hitting for 2 unstalled cycles.
//   - Response: perf_hit_count=8. A following rst gives 0.

Source files
------------

// File: rtl/bypass_select_ctrl_if.sv
// Bypass select interface: producer tags and consumer source tags in, registered select out.
// master drives the tags/control; slave (bypass_select_ctrl) returns the per-operand select.
interface bypass_select_ctrl_if #(
    parameter int unsigned INT_LANES = 2,
    parameter int unsigned MEM_LANES = 2,
    parameter int unsigned CONSUMERS = 4,
    parameter int unsigned PREG_W    = 7,
    parameter int unsigned LANE_W    = 1
) ();
    logic                          stall;
    logic                          clear;
    logic [INT_LANES-1:0]          int_dst_valid;
    logic [INT_LANES*PREG_W-1:0]   int_dst_preg;
    logic [MEM_LANES-1:0]          mem_dst_valid;
    logic [MEM_LANES*PREG_W-1:0]   mem_dst_preg;
    logic [CONSUMERS-1:0]          src_valid;
    logic [CONSUMERS*PREG_W-1:0]   src_preg;
    logic [CONSUMERS*3-1:0]        sel_stg;
    logic [CONSUMERS*LANE_W-1:0]   sel_lane;
    logic [CONSUMERS-1:0]          sel_hit;

    modport master (
        output stall, clear, int_dst_valid, int_dst_preg, mem_dst_valid, mem_dst_preg,
               src_valid, src_preg,
        input  sel_stg, sel_lane, sel_hit
    );

    modport slave (
        input  stall, clear, int_dst_valid, int_dst_preg, mem_dst_valid, mem_dst_preg,
               src_valid, src_preg,
        output sel_stg, sel_lane, sel_hit
    );
endinterface

// File: rtl/bypass_select_ctrl.sv
// Bypass select control: tracks producer tags through EX/MA and emits a registered per-operand
// {stg, lane} select. Optional hit counter enabled by defining BYPASS_CTRL_PERF_EN.
module bypass_select_ctrl #(
    parameter int unsigned INT_LANES = 2,
    parameter int unsigned MEM_LANES = 2,
    parameter int unsigned CONSUMERS = 4,
    parameter int unsigned PREG_W    = 7,
    parameter int unsigned LANE_W    = 1
) (
    input  logic                clk,
    input  logic                rst,
    bypass_select_ctrl_if.slave bus
`ifdef BYPASS_CTRL_PERF_EN
    ,
    output logic [31:0]         perf_hit_count
`endif
);
    localparam logic [2:0] StgNone  = 3'd0;
    localparam logic [2:0] StgIntEx = 3'd1;
    localparam logic [2:0] StgIntWb = 3'd2;
    localparam logic [2:0] StgMemMa = 3'd3;
    localparam logic [2:0] StgMemWb = 3'd4;

    // WB tags are never compared, so only the EX/MA stage of each tag pipe is stored.
    logic [INT_LANES-1:0]        ex_valid_q, ex_valid_d;
    logic [INT_LANES*PREG_W-1:0] ex_preg_q, ex_preg_d;
    logic [MEM_LANES-1:0]        ma_valid_q, ma_valid_d;
    logic [MEM_LANES*PREG_W-1:0] ma_preg_q, ma_preg_d;

    logic [CONSUMERS*3-1:0]      sel_stg_q, sel_stg_d;
    logic [CONSUMERS*LANE_W-1:0] sel_lane_q, sel_lane_d;
    logic [CONSUMERS-1:0]        sel_hit_q, sel_hit_d;

    logic [CONSUMERS*3-1:0]      cmp_stg;
    logic [CONSUMERS*LANE_W-1:0] cmp_lane;
    logic [CONSUMERS-1:0]        cmp_hit;

    // Scan producers youngest first; the first match per operand wins.
    always_comb begin
        cmp_stg  = '0;
        cmp_lane = '0;
        cmp_hit  = '0;
        for (int c = 0; c < CONSUMERS; c++) begin
            if (bus.src_valid[c]) begin
                for (int i = 0; i < INT_LANES; i++) begin
                    if (!cmp_hit[c] && bus.int_dst_valid[i] &&
                        bus.int_dst_preg[i*PREG_W +: PREG_W] == bus.src_preg[c*PREG_W +: PREG_W]) begin
                        cmp_hit[c]                  = 1'b1;
                        cmp_stg[c*3 +: 3]           = StgIntEx;
                        cmp_lane[c*LANE_W +: LANE_W] = LANE_W'(i);
                    end
                end
                for (int i = 0; i < MEM_LANES; i++) begin
                    if (!cmp_hit[c] && bus.mem_dst_valid[i] &&
                        bus.mem_dst_preg[i*PREG_W +: PREG_W] == bus.src_preg[c*PREG_W +: PREG_W]) begin
                        cmp_hit[c]                  = 1'b1;
                        cmp_stg[c*3 +: 3]           = StgMemMa;
                        cmp_lane[c*LANE_W +: LANE_W] = LANE_W'(i);
                    end
                end
                for (int i = 0; i < INT_LANES; i++) begin
                    if (!cmp_hit[c] && ex_valid_q[i] &&
                        ex_preg_q[i*PREG_W +: PREG_W] == bus.src_preg[c*PREG_W +: PREG_W]) begin
                        cmp_hit[c]                  = 1'b1;
                        cmp_stg[c*3 +: 3]           = StgIntWb;
                        cmp_lane[c*LANE_W +: LANE_W] = LANE_W'(i);
                    end
                end
                for (int i = 0; i < MEM_LANES; i++) begin
                    if (!cmp_hit[c] && ma_valid_q[i] &&
                        ma_preg_q[i*PREG_W +: PREG_W] == bus.src_preg[c*PREG_W +: PREG_W]) begin
                        cmp_hit[c]                  = 1'b1;
                        cmp_stg[c*3 +: 3]           = StgMemWb;
                        cmp_lane[c*LANE_W +: LANE_W] = LANE_W'(i);
                    end
                end
            end
        end
    end

    // clear dominates stall; tag values may stay stale once their valid drops.
    always_comb begin
        ex_valid_d = ex_valid_q;
        ex_preg_d  = ex_preg_q;
        ma_valid_d = ma_valid_q;
        ma_preg_d  = ma_preg_q;
        sel_stg_d  = sel_stg_q;
        sel_lane_d = sel_lane_q;
        sel_hit_d  = sel_hit_q;
        if (bus.clear) begin
            ex_valid_d = '0;
            ma_valid_d = '0;
            sel_stg_d  = '0;
            sel_lane_d = '0;
            sel_hit_d  = '0;
        end else if (!bus.stall) begin
            ex_valid_d = bus.int_dst_valid;
            ex_preg_d  = bus.int_dst_preg;
            ma_valid_d = bus.mem_dst_valid;
            ma_preg_d  = bus.mem_dst_preg;
            sel_stg_d  = cmp_stg;
            sel_lane_d = cmp_lane;
            sel_hit_d  = cmp_hit;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_q <= '0;
            ex_preg_q  <= '0;
            ma_valid_q <= '0;
            ma_preg_q  <= '0;
            sel_stg_q  <= '0;
            sel_lane_q <= '0;
            sel_hit_q  <= '0;
        end else begin
            ex_valid_q <= ex_valid_d;
            ex_preg_q  <= ex_preg_d;
            ma_valid_q <= ma_valid_d;
            ma_preg_q  <= ma_preg_d;
            sel_stg_q  <= sel_stg_d;
            sel_lane_q <= sel_lane_d;
            sel_hit_q  <= sel_hit_d;
        end
    end

    assign bus.sel_stg  = sel_stg_q;
    assign bus.sel_lane = sel_lane_q;
    assign bus.sel_hit  = sel_hit_q;

`ifdef BYPASS_CTRL_PERF_EN
    logic [31:0] perf_q, perf_d;

    always_comb begin
        perf_d = perf_q;
        if (!bus.clear && !bus.stall) begin
            perf_d = perf_q + 32'($countones(cmp_hit));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign perf_hit_count = perf_q;
`endif
endmodule
